wall_rom_arbiter: RTL and testbench
===================================

# wall_rom_arbiter

Round-robin arbiter and read sequencer that shares one combinational wall-map ROM port (8-bit address, 4-bit tile code, 167 entries) among several requesters: Pac-Man movement, ghost AI and the tile renderer. It accepts one lookup per cycle, drives the ROM address from a pipeline register, and returns the tile code to the winning requester a fixed two cycles after acceptance.

## Interface
- NUM_REQ, 3, number of requesters; must be 2..8
- ADDR_WIDTH, 8, ROM address width
- DATA_WIDTH, 4, ROM data width
- ROM_DEPTH, 167, valid ROM entries; addresses 0..ROM_DEPTH-1
- Clk  input  1  system clock; all state changes on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- enable  input  1  high allows new grants; low blocks grants while the pipeline drains
- req_valid  input  NUM_REQ  per-requester lookup request
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  output  NUM_REQ  one-hot grant, combinational from req_valid, enable and pointer
- rsp_valid  output  NUM_REQ  one-hot, high for one cycle when rsp_data belongs to requester i
- rsp_data  output  DATA_WIDTH  registered tile code, shared by all requesters
- rom_addr  output  ADDR_WIDTH  registered address to the ROM
- rom_data  input  DATA_WIDTH  combinational ROM output for rom_addr

## Operation
- Round-robin pointer ptr (0..NUM_REQ-1). Winner = first i with req_valid[i] scanning ptr, ptr+1, ... modulo NUM_REQ.
- req_ready[winner]=1 when enable=1 and some req_valid is high; all other bits 0. At most one bit of req_ready is set.
- Accept = req_valid[i] & req_ready[i]. On accept: ptr <= (winner+1) mod NUM_REQ; stage-1 registers load address, requester id and s1_valid=1.
- No accept: ptr holds; s1_valid <= 0.
- Stage 1: rom_addr = registered address. Stage 2: rsp_data <= rom_data; rsp_valid <= one-hot(s1_id) if s1_valid, else 0.
- Requester holds req_valid and req_addr stable until req_ready; deasserting req_valid before grant withdraws the request.
- enable low: no new accepts; in-flight stage-1/stage-2 entries still complete. ptr does not change.
- rom_addr and rsp_data hold their last values when no lookup is in flight.
- Reset (any time, including mid-lookup): ptr=0, s1_valid=0, rom_addr=0, rsp_valid=0, rsp_data=0; in-flight lookups are discarded with no response.

## Timing
- Accept in cycle N -> rom_addr valid during N+1 -> rsp_valid/rsp_data during N+2. Latency 2, throughput 1 per cycle.
- Back-to-back accepts from the same or different requesters are pipelined; responses return in accept order.
- req_ready has no dependency on rsp path; no combinational path from rom_data to any output.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles while enable=1.

## Configuration
- WALL_ROM_BOUNDS_CHECK_EN defined: an accepted address >= ROM_DEPTH drives rom_addr=0 and returns rsp_data = all ones (4'b1111, solid wall) with the same 2-cycle latency.
- Not defined: address passes unchanged to rom_addr and rsp_data = rom_data; out-of-range results are unspecified and callers must not issue them.

## Test plan
- Reset: assert Reset_n=0 mid-lookup -> all outputs 0 immediately, no rsp_valid after release; first grant after release goes to requester 0 when all valid.
- Single lookup: req_valid=3'b010, addr 8'd20 accepted cycle N -> rom_addr=20 at N+1, rsp_valid=3'b010 and rsp_data=ROM[20] at N+2.
- Round robin: all three valid continuously for 6 cycles -> grants 0,1,2,0,1,2; responses in same order at +2.
- Enable gating: enable dropped one cycle after an accept -> req_ready=0, that accepted lookup still returns; ptr unchanged on re-enable.
- Pointer skip: ptr=1, only requester 0 valid -> grant 0, ptr becomes 1.
- Bounds (macro defined): accept addr 8'd200 -> rom_addr=0, rsp_data=4'b1111 two cycles later.

Source files
------------

// File: rtl/wall_rom_arbiter.sv
// Round-robin arbiter sharing one combinational wall-map ROM port; fixed 2-cycle lookup latency.
// Optional macro WALL_ROM_BOUNDS_CHECK_EN: out-of-range addresses read as solid wall (all ones).
module wall_rom_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 4,
   parameter int ROM_DEPTH  = 167
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic                          enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [ID_W-1:0]       ptr;
   logic [ID_W-1:0]       winner_p0;
   logic                  accept_p0;
   logic [ADDR_WIDTH-1:0] addr_p0;
   logic                  oob_p0;
   logic                  vld_p1;
   logic [ID_W-1:0]       id_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic                  oob_p1;

   // Pick the valid requester closest to ptr going upward, wrapping at NUM_REQ.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    p);
      int              best_d;
      int              d;
      logic [ID_W-1:0] w;
      best_d = NUM_REQ;
      w      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         d = i - int'(p);
         if (d < 0) d = d + NUM_REQ;
         if (v[i] && (d < best_d)) begin
            best_d = d;
            w      = ID_W'(i);
         end
      end
      return w;
   endfunction

   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] w);
      int n;
      n = int'(w) + 1;
      if (n >= NUM_REQ) n = 0;
      return ID_W'(n);
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(id) == i) oh[i] = 1'b1;
      end
      return oh;
   endfunction

`ifdef WALL_ROM_BOUNDS_CHECK_EN
   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return (int'(a) >= ROM_DEPTH);
   endfunction

   assign oob_p0 = out_of_range(addr_p0);
`else
   assign oob_p0 = 1'b0;
`endif

   // Stage 0: arbitration and address select
   always_comb begin
      req_ready = '0;
      addr_p0   = '0;
      winner_p0 = rr_pick(req_valid, ptr);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (int'(winner_p0) == i) begin
            req_ready[i] = enable & req_valid[i];
            addr_p0      = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign accept_p0 = |(req_valid & req_ready);

   // Stage 1: registered ROM address
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr     <= '0;
         vld_p1  <= 1'b0;
         id_p1   <= '0;
         addr_p1 <= '0;
         oob_p1  <= 1'b0;
      end else begin
         vld_p1 <= accept_p0;
         if (accept_p0) begin
            ptr     <= rr_next(winner_p0);
            id_p1   <= winner_p0;
            addr_p1 <= oob_p0 ? '0 : addr_p0;
            oob_p1  <= oob_p0;
         end
      end
   end

   assign rom_addr = addr_p1;

   // Stage 2: registered response
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= vld_p1 ? onehot(id_p1) : '0;
         if (vld_p1) rsp_data <= oob_p1 ? '1 : rom_data;
      end
   end

endmodule

// File: tb/tb_wall_rom_arbiter.sv
// Directed, table-driven bench for wall_rom_arbiter with a behavioural ROM model.
module tb_wall_rom_arbiter;

   logic        Clk;
   logic        Reset_n;
   logic        enable;
   logic [2:0]  req_valid;
   logic [23:0] req_addr;
   logic [2:0]  req_ready;
   logic [2:0]  rsp_valid;
   logic [3:0]  rsp_data;
   logic [7:0]  rom_addr;
   logic [3:0]  rom_data;

   logic [7:0]  a0, a1, a2;
   int          n_checks;
   int          n_err;

   typedef struct {
      logic       en;
      logic [2:0] vld;
      logic [2:0] rdy;
      logic [7:0] raddr;
      logic [2:0] rvld;
      logic [3:0] rdata;
   } vec_t;

   vec_t tbl[19];

   wall_rom_arbiter #(
      .NUM_REQ(3), .ADDR_WIDTH(8), .DATA_WIDTH(4), .ROM_DEPTH(167)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .enable(enable),
      .req_valid(req_valid),
      .req_addr(req_addr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_data(rsp_data),
      .rom_addr(rom_addr),
      .rom_data(rom_data)
   );

   function automatic logic [3:0] rom_fn(input logic [7:0] a);
      return a[3:0] ^ a[7:4] ^ 4'h3;
   endfunction

   always_comb rom_data = rom_fn(rom_addr);
   assign req_addr = {a2, a1, a0};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   localparam logic [7:0] A0 = 8'd45;
   localparam logic [7:0] A1 = 8'd20;
   localparam logic [7:0] A2 = 8'd100;

   initial begin
      n_checks  = 0;
      n_err     = 0;
      Reset_n   = 1'b0;
      enable    = 1'b0;
      req_valid = 3'b000;
      a0 = A0; a1 = A1; a2 = A2;

      //           en    vld     rdy     rom_addr rsp_vld data
      tbl[0]  = '{1'b1, 3'b111, 3'b001, 8'd0, 3'b000, 4'h0};
      tbl[1]  = '{1'b1, 3'b111, 3'b010, A0,   3'b000, 4'h0};
      tbl[2]  = '{1'b1, 3'b111, 3'b100, A1,   3'b001, rom_fn(A0)};
      tbl[3]  = '{1'b1, 3'b111, 3'b001, A2,   3'b010, rom_fn(A1)};
      tbl[4]  = '{1'b1, 3'b111, 3'b010, A0,   3'b100, rom_fn(A2)};
      tbl[5]  = '{1'b1, 3'b111, 3'b100, A1,   3'b001, rom_fn(A0)};
      tbl[6]  = '{1'b0, 3'b111, 3'b000, A2,   3'b010, rom_fn(A1)};
      tbl[7]  = '{1'b0, 3'b111, 3'b000, A2,   3'b100, rom_fn(A2)};
      tbl[8]  = '{1'b0, 3'b000, 3'b000, A2,   3'b000, rom_fn(A2)};
      tbl[9]  = '{1'b1, 3'b111, 3'b001, A2,   3'b000, rom_fn(A2)};
      tbl[10] = '{1'b1, 3'b001, 3'b001, A0,   3'b000, rom_fn(A2)};
      tbl[11] = '{1'b1, 3'b010, 3'b010, A0,   3'b001, rom_fn(A0)};
      tbl[12] = '{1'b1, 3'b000, 3'b000, A1,   3'b001, rom_fn(A0)};
      tbl[13] = '{1'b1, 3'b000, 3'b000, A1,   3'b010, rom_fn(A1)};
      tbl[14] = '{1'b1, 3'b000, 3'b000, A1,   3'b000, rom_fn(A1)};
      tbl[15] = '{1'b1, 3'b101, 3'b100, A1,   3'b000, rom_fn(A1)};
      tbl[16] = '{1'b1, 3'b011, 3'b001, A2,   3'b000, rom_fn(A1)};
      tbl[17] = '{1'b1, 3'b000, 3'b000, A0,   3'b100, rom_fn(A2)};
      tbl[18] = '{1'b1, 3'b000, 3'b000, A0,   3'b001, rom_fn(A0)};

      #1;
      chk("reset_rom_addr",  32'(rom_addr),  32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_data",  32'(rsp_data),  32'h0);
      chk("reset_req_ready", 32'(req_ready), 32'h0);

      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         enable    = tbl[i].en;
         req_valid = tbl[i].vld;
         #1;
         chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_rom_addr", i),  32'(rom_addr),  32'(tbl[i].raddr));
         chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rvld));
         chk($sformatf("v%0d_rsp_data", i),  32'(rsp_data),  32'(tbl[i].rdata));
         @(negedge Clk);
      end

`ifdef WALL_ROM_BOUNDS_CHECK_EN
      // ptr is 1 here; only requester 0 asks, with an out-of-range address
      a0        = 8'd200;
      enable    = 1'b1;
      req_valid = 3'b001;
      #1;
      chk("oob_req_ready", 32'(req_ready), 32'b001);
      @(negedge Clk);
      req_valid = 3'b000;
      #1;
      chk("oob_rom_addr", 32'(rom_addr), 32'h0);
      @(negedge Clk);
      #1;
      chk("oob_rsp_valid", 32'(rsp_valid), 32'b001);
      chk("oob_rsp_data",  32'(rsp_data),  32'hF);
      @(negedge Clk);
      a0 = A0;
`endif

      // Reset asserted with two lookups in flight
      enable    = 1'b1;
      req_valid = 3'b111;
      @(negedge Clk);
      @(negedge Clk);
      #1;
      chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'b010);
      chk("pre_reset_rom_addr",  32'(rom_addr),  32'(A2));
      enable    = 1'b0;
      req_valid = 3'b000;
      Reset_n   = 1'b0;
      #1;
      chk("midrst_rom_addr",  32'(rom_addr),  32'h0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_rsp_data",  32'(rsp_data),  32'h0);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("postrst_rsp_valid_%0d", k), 32'(rsp_valid), 32'h0);
         @(negedge Clk);
      end
      enable    = 1'b1;
      req_valid = 3'b111;
      #1;
      chk("postrst_first_grant", 32'(req_ready), 32'b001);
      @(negedge Clk);
      req_valid = 3'b000;
      #1;
      chk("postrst_rom_addr", 32'(rom_addr), 32'(A0));
      @(negedge Clk);
      #1;
      chk("postrst_rsp_valid", 32'(rsp_valid), 32'b001);
      chk("postrst_rsp_data",  32'(rsp_data),  32'(rom_fn(A0)));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
